mp_add_sequencer: RTL and testbench



---
 rtl/mp_add_pkg.sv | 19 +
 rtl/mp_add_slice.sv | 23 ++
 rtl/mp_add_sequencer.sv | 116 +++++++++++
 tb/tb_mp_add_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and sizing helpers for the multi-precision slice adder.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int op_w(input int slice_w, input int num_slices);
    return slice_w * num_slices;
  endfunction

  // Slice counter width; a single-slice build still needs one bit.
  function automatic int idx_w(input int num_slices);
    return (num_slices <= 1) ? 1 : $clog2(num_slices);
  endfunction

endpackage

// File: rtl/mp_add_slice.sv
// Combinational SLICE_W-bit ripple-carry slice built from full-adder equations.
module mp_add_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-cycle adder: steps one ripple slice across the operands, LS slice first.
// Optional subtract mode (port op) is enabled by defining MP_ADD_SUB_EN.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int SLICE_W    = 4,
  parameter int NUM_SLICES = 4,
  localparam int OP_W      = op_w(SLICE_W, NUM_SLICES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] a,
`ifdef MP_ADD_SUB_EN
  input  logic            op,
`endif
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] sum,
  output logic            cout,
  output logic            busy
);

  localparam int IDX_W = idx_w(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               c_sl;

  assign a_sl = a_q[idx*SLICE_W +: SLICE_W];
  assign b_sl = b_q[idx*SLICE_W +: SLICE_W];

  mp_add_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
`ifdef MP_ADD_SUB_EN
            // Two's-complement subtract: invert b and inject the +1 as carry-in.
            b_q   <= op ? ~b : b;
            carry <= op ? 1'b1 : cin;
`else
            b_q   <= b;
            carry <= cin;
`endif
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*SLICE_W +: SLICE_W] <= s_sl;
          carry <= c_sl;
          if (idx == LAST_IDX) begin
            // idx parks on the last slice rather than wrapping.
            cout      <= c_sl;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed, table-driven bench for mp_add_sequencer (default 4x4-bit slices).
module tb_mp_add_sequencer;

  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 4;
  localparam int OP_W       = SLICE_W * NUM_SLICES;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            cout;
  logic            busy;
`ifdef MP_ADD_SUB_EN
  logic            op;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
    logic [OP_W-1:0] sum;
    logic            cout;
  } vec_t;

  vec_t vecs[8];

  mp_add_sequencer #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
`ifdef MP_ADD_SUB_EN
    .op        (op),
`endif
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Waits (bounded) for in_ready, then presents operands for exactly one edge.
  task automatic start_op(input logic [OP_W-1:0] ta, input logic [OP_W-1:0] tb_v, input logic tc);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    check({nm, "_latency"}, 32'(lat), 32'(NUM_SLICES));
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_ovalid_drop"}, 32'(out_valid), 32'd0);
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    start_op(v.a, v.b, v.cin);
    wait_valid(nm);
    check({nm, "_sum"}, 32'(sum), 32'(v.sum));
    check({nm, "_cout"}, 32'(cout), 32'(v.cout));
    check({nm, "_busy"}, 32'(busy), 32'd1);
    release_result(nm);
  endtask

  initial begin
    int acc_cyc[4];
    logic [OP_W-1:0] bb_a[4];
    logic [OP_W-1:0] bb_b[4];
    vec_t v;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef MP_ADD_SUB_EN
    op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result must hold and a stray in_valid must be ignored.
    start_op(16'hBEEF, 16'h1111, 1'b0);
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a = 16'h0000; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_sum%0d", i), 32'(sum), 32'h0000D000);
      check($sformatf("bp_hold_cout%0d", i), 32'(cout), 32'd0);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    release_result("bp");
    @(posedge clk); #1;
    check("bp_no_stray_accept", 32'(busy), 32'd0);

    // Asynchronous reset while idx==2 discards the partial operation.
    start_op(16'hFFFF, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ovalid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_no_result", 32'(out_valid), 32'd0);
    v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    run_vec("post_rst", v);

    // Back-to-back with in_valid held and out_ready tied high.
    bb_a = '{16'h0010, 16'hFFF0, 16'h7777, 16'h4321};
    bb_b = '{16'h0020, 16'h0010, 16'h1111, 16'h1234};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      a = bb_a[i]; b = bb_b[i]; cin = 1'b0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b_sum%0d", i), 32'(sum), 32'((bb_a[i] + bb_b[i]) & 16'hFFFF));
      check($sformatf("b2b_cout%0d", i), 32'(cout), 32'(({1'b0, bb_a[i]} + {1'b0, bb_b[i]}) >> OP_W));
      if (i > 0) check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NUM_SLICES + 2));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;

`ifdef MP_ADD_SUB_EN
    op = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    wait_valid("sub0");
    check("sub0_sum", 32'(sum), 32'h0000FFFE);
    check("sub0_cout", 32'(cout), 32'd0);
    release_result("sub0");
    start_op(16'h0007, 16'h0005, 1'b0);
    wait_valid("sub1");
    check("sub1_sum", 32'(sum), 32'h00000002);
    check("sub1_cout", 32'(cout), 32'd1);
    release_result("sub1");
    op = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
